sdf_pair_buffer: RTL and testbench



---
 rtl/fft_pkg.sv | 35 +++
 rtl/sdf_pair_buffer_sdp_ram.sv | 35 +++
 rtl/sdf_pair_buffer.sv | 139 +++++++++++++
 tb/tb_sdf_pair_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared FFT datapath types, defaults and constant helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int DEF_FLOAT_LEN    = 32;
    localparam int DEF_MAX_LOG_HALF = 12;

    typedef struct packed {
        logic [DEF_FLOAT_LEN-1:0] re;
        logic [DEF_FLOAT_LEN-1:0] im;
    } complex_t;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                res = res + 1;
                v   = v >>> 1;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdf_pair_buffer_sdp_ram.sv
// ============================================================================
// Module   : sdp_ram
// Purpose  : Simple dual-port RAM, one write port, one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_ram #(
    parameter int DW = 64,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] r_mem [2**AW];

    // Read register only loads on rd_en, so the last read word is held.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdf_pair_buffer.sv
// ============================================================================
// Module   : sdf_pair_buffer
// Purpose  : Radix-2 SDF input buffer, pairs first-half with second-half data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdf_pair_buffer
    import fft_pkg::*;
#(
    parameter  int FLOAT_LEN    = DEF_FLOAT_LEN,
    parameter  int MAX_LOG_HALF = DEF_MAX_LOG_HALF,
    parameter  int CFG_W        = 4,
    localparam int DW           = 2 * FLOAT_LEN,
    localparam int CW           = MAX_LOG_HALF + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    input  logic [CFG_W-1:0] cfg_log_half,
    input  logic [DW-1:0]    din,
    input  logic             din_valid,
    output logic [DW-1:0]    x1,
    output logic [DW-1:0]    x2,
    output logic             pair_valid,
    output logic             frame_done,
    output logic             busy,
    output logic [CW-1:0]    fill_level,
    output logic             cfg_err
);

    localparam int AW = MAX_LOG_HALF;
    localparam int LW = (clog2(MAX_LOG_HALF + 1) < 1) ? 1 : clog2(MAX_LOG_HALF + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_fill;
    logic [LW-1:0] r_act_log;
    logic [DW-1:0] r_x2;
    logic          r_pair_valid;
    logic          r_frame_done;
    logic          r_cfg_err;
    logic          r_x1_live;

    logic [LW-1:0] w_log_eff;
    logic [CW-1:0] w_half;
    logic [CW-1:0] w_last;
    logic          w_first;
    logic          w_cfg_over;
    logic          w_fill_phase;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_rd_data;

    // The first sample of a frame already uses the freshly requested size.
    always_comb begin
        w_first    = (r_cnt == '0);
        w_cfg_over = (cfg_log_half > CFG_W'(MAX_LOG_HALF));
        w_log_eff  = r_act_log;
        if (w_first) begin
            w_log_eff = w_cfg_over ? LW'(MAX_LOG_HALF) : LW'(cfg_log_half);
        end
        w_half       = CW'(1) << w_log_eff;
        w_last       = w_half | (w_half - CW'(1));
        w_fill_phase = (r_cnt < w_half);
        w_wr_en      = din_valid & w_fill_phase;
        w_rd_en      = din_valid & ~w_fill_phase;
        w_wr_addr    = r_cnt[AW-1:0];
        w_rd_addr    = AW'(r_cnt - w_half);
    end

    sdp_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (din),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_fill       <= '0;
            r_act_log    <= '0;
            r_x2         <= '0;
            r_pair_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_x1_live    <= 1'b0;
        end else if (sclr) begin
            r_cnt        <= '0;
            r_fill       <= '0;
            r_act_log    <= '0;
            r_x2         <= '0;
            r_pair_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_x1_live    <= 1'b0;
        end else if (din_valid) begin
            r_act_log <= w_log_eff;
            if (w_first && w_cfg_over) begin
                r_cfg_err <= 1'b1;
            end
            r_cnt <= (r_cnt == w_last) ? '0 : r_cnt + CW'(1);
            if (w_fill_phase) begin
                r_fill       <= r_cnt + CW'(1);
                r_pair_valid <= 1'b0;
                r_frame_done <= 1'b0;
            end else begin
                r_fill       <= r_fill - CW'(1);
                r_pair_valid <= 1'b1;
                r_frame_done <= (r_cnt == w_last);
                r_x2         <= din;
                r_x1_live    <= 1'b1;
            end
        end else begin
            r_pair_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end
    end

    // RAM read register is not reset; mask it until a pair has been read.
    assign x1         = r_x1_live ? w_rd_data : '0;
    assign x2         = r_x2;
    assign pair_valid = r_pair_valid;
    assign frame_done = r_frame_done;
    assign busy       = (r_cnt != '0);
    assign fill_level = r_fill;
    assign cfg_err    = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_sdf_pair_buffer.sv
// ============================================================================
// Module   : tb_sdf_pair_buffer
// Purpose  : Directed self-checking bench for sdf_pair_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdf_pair_buffer;

    localparam int FLOAT_LEN    = 32;
    localparam int MAX_LOG_HALF = 12;
    localparam int CFG_W        = 4;
    localparam int DW           = 2 * FLOAT_LEN;
    localparam int CW           = MAX_LOG_HALF + 1;

    logic             clk;
    logic             rst;
    logic             sclr;
    logic [CFG_W-1:0] cfg_log_half;
    logic [DW-1:0]    din;
    logic             din_valid;
    logic [DW-1:0]    x1;
    logic [DW-1:0]    x2;
    logic             pair_valid;
    logic             frame_done;
    logic             busy;
    logic [CW-1:0]    fill_level;
    logic             cfg_err;

    int errors = 0;
    int checks = 0;

    sdf_pair_buffer #(
        .FLOAT_LEN    (FLOAT_LEN),
        .MAX_LOG_HALF (MAX_LOG_HALF),
        .CFG_W        (CFG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sclr         (sclr),
        .cfg_log_half (cfg_log_half),
        .din          (din),
        .din_valid    (din_valid),
        .x1           (x1),
        .x2           (x2),
        .pair_valid   (pair_valid),
        .frame_done   (frame_done),
        .busy         (busy),
        .fill_level   (fill_level),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one input, let the edge take it, sample 1 time unit later.
    task automatic step(input logic v, input int data);
        din_valid = v;
        din       = 64'(data);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pair(input string tag, input int e1, input int e2, input logic efd);
        chk({tag, "_pv"}, 64'(pair_valid), 64'(1));
        chk({tag, "_x1"}, x1, 64'(e1));
        chk({tag, "_x2"}, x2, 64'(e2));
        chk({tag, "_fd"}, 64'(frame_done), 64'(efd));
    endtask

    task automatic expect_all_zero(input string tag);
        chk({tag, "_x1"}, x1, 64'(0));
        chk({tag, "_x2"}, x2, 64'(0));
        chk({tag, "_pv"}, 64'(pair_valid), 64'(0));
        chk({tag, "_fd"}, 64'(frame_done), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_fill"}, 64'(fill_level), 64'(0));
        chk({tag, "_err"}, 64'(cfg_err), 64'(0));
    endtask

    initial begin
        int seen_pv;

        rst          = 1'b1;
        sclr         = 1'b0;
        cfg_log_half = 4'd2;
        din          = '0;
        din_valid    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_all_zero("reset");
        rst = 1'b0;

        // HALF=4, single frame 1..8
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, i);
            if (i <= 4) begin
                chk("t1_fill_pv", 64'(pair_valid), 64'(0));
                chk("t1_fill_lvl", 64'(fill_level), 64'(i));
            end else begin
                expect_pair("t1_pair", i - 4, i, (i == 8));
                chk("t1_pair_lvl", 64'(fill_level), 64'(8 - i));
            end
            if (i == 1) chk("t1_busy_hi", 64'(busy), 64'(1));
        end
        chk("t1_busy_lo", 64'(busy), 64'(0));
        step(1'b0, 99);
        chk("t1_gap_pv", 64'(pair_valid), 64'(0));
        chk("t1_hold_x1", x1, 64'(4));
        chk("t1_hold_x2", x2, 64'(8));

        // HALF=4, two back-to-back frames 1..16
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, i);
            if (i >= 9 && i <= 12) chk("t2_fill_pv", 64'(pair_valid), 64'(0));
            if (i >= 13) expect_pair("t2_pair", i - 4, i, (i == 16));
        end

        // HALF=8, din_valid toggling
        cfg_log_half = 4'd3;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, i);
            if (i <= 8) chk("t3_fill_pv", 64'(pair_valid), 64'(0));
            else expect_pair("t3_pair", i - 8, i, (i == 16));
            step(1'b0, 32'hdead);
            chk("t3_gap_pv", 64'(pair_valid), 64'(0));
            if (i > 8) begin
                chk("t3_gap_x1", x1, 64'(i - 8));
                chk("t3_gap_x2", x2, 64'(i));
            end
        end

        // HALF=2, cfg changed mid-frame, next frame HALF=8
        cfg_log_half = 4'd1;
        step(1'b1, 1);
        step(1'b1, 2);
        cfg_log_half = 4'd3;
        step(1'b1, 3);
        expect_pair("t4_p1", 1, 3, 1'b0);
        step(1'b1, 4);
        expect_pair("t4_p2", 2, 4, 1'b1);
        chk("t4_busy_end", 64'(busy), 64'(0));
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, i);
            if (i == 8) begin
                chk("t4_f2_pv8", 64'(pair_valid), 64'(0));
                chk("t4_f2_lvl8", 64'(fill_level), 64'(8));
            end
            if (i == 9)  expect_pair("t4_f2_p9", 1, 9, 1'b0);
            if (i == 16) expect_pair("t4_f2_p16", 8, 16, 1'b1);
        end

        // Out-of-range cfg clamps to HALF=4096
        cfg_log_half = 4'd15;
        seen_pv = 0;
        for (int i = 1; i <= 4096; i++) begin
            step(1'b1, i);
            if (pair_valid) seen_pv++;
            if (i == 1) chk("t5_err_set", 64'(cfg_err), 64'(1));
        end
        chk("t5_no_early_pair", 64'(seen_pv), 64'(0));
        chk("t5_lvl_full", 64'(fill_level), 64'(4096));
        step(1'b1, 4097);
        expect_pair("t5_first_pair", 1, 4097, 1'b0);
        chk("t5_err_sticky", 64'(cfg_err), 64'(1));
        sclr = 1'b1;
        step(1'b1, 4098);
        sclr = 1'b0;
        expect_all_zero("t5_sclr");

        // Async reset mid-frame, then a clean frame 10..17
        cfg_log_half = 4'd2;
        step(1'b1, 1);
        step(1'b1, 2);
        step(1'b1, 3);
        chk("t6_busy_pre", 64'(busy), 64'(1));
        chk("t6_lvl_pre", 64'(fill_level), 64'(3));
        rst = 1'b1;
        #1;
        expect_all_zero("t6_rst_async");
        step(1'b1, 77);
        expect_all_zero("t6_rst_held");
        rst = 1'b0;
        for (int i = 10; i <= 17; i++) begin
            step(1'b1, i);
            if (i <= 13) chk("t6_fill_pv", 64'(pair_valid), 64'(0));
            else expect_pair("t6_pair", i - 4, i, (i == 17));
        end

        din_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
